rf_wb_queue: RTL and testbench

- Writeback buffer for the three-ported register file's write port (we3/wa3/wd3). It is the write-side initiator for that port.
- Accepts register writes from multi-cycle producers (load unit, multiplier) over a valid/ready handshake and holds them in a DEPTH-entry FIFO.
- Drains one entry per cycle into the register file whenever the main pipeline writeback is idle. The pipeline writeback always has priority.
- Reports per-address pending status so decode can stall on read-after-write hazards against queued writes.

---
 rtl/rf_pkg.sv | 14 +
 rtl/rf_wb_fifo.sv | 90 +++++++++
 rtl/rf_wb_queue.sv | 94 +++++++++
 tb/tb_rf_wb_queue.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared register-file types and constants for the writeback path.
// rf_wr_t is one pending register write: destination address plus data.
package rf_pkg;

    localparam int RF_AW = 5;
    localparam int RF_DW = 32;
    localparam logic [RF_AW-1:0] RF_ZERO_ADDR = '0;

    typedef struct packed {
        logic [RF_AW-1:0] wa;
        logic [RF_DW-1:0] wd;
    } rf_wr_t;

endpackage

// File: rtl/rf_wb_fifo.sv
// Generic DEPTH-entry FIFO of register writes.
// Exposes per-entry valid bits and addresses so the parent can run hazard compares.
module rf_wb_fifo
    import rf_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        push,
    input  rf_wr_t                      push_data,
    input  logic                        pop,
    output rf_wr_t                      head_data,
    output logic [CW-1:0]               count,
    output logic [DEPTH-1:0]            ent_valid,
    output logic [DEPTH-1:0][RF_AW-1:0] ent_wa
);

    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    rf_wr_t             mem_q [DEPTH];
    rf_wr_t             mem_d [DEPTH];
    logic [DEPTH-1:0]   valid_q, valid_d;
    logic [PW-1:0]      head_q, head_d;
    logic [PW-1:0]      tail_q, tail_d;
    logic [CW-1:0]      count_q, count_d;
    logic               push_ok, pop_ok;

    // Guard here as well so a misbehaving parent can never corrupt the pointers.
    assign push_ok = push && (count_q != FULL_CNT);
    assign pop_ok  = pop && (count_q != '0);

    always_comb begin
        mem_d   = mem_q;
        valid_d = valid_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (pop_ok) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PTR_ONE;
        end
        if (push_ok) begin
            mem_d[tail_q]   = push_data;
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + PTR_ONE;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage needs no reset; the valid bits gate every use of it.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_wa[i] = mem_q[i].wa;
        end
    end

    assign head_data = mem_q[head_q];
    assign count     = count_q;
    assign ent_valid = valid_q;

endmodule

// File: rtl/rf_wb_queue.sv
// Writeback buffer in front of the register file write port: queues producer writes
// and drains them whenever the main pipeline writeback is idle.
module rf_wb_queue
    import rf_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = RF_AW,
    parameter int DW    = RF_DW
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     pipe_we,
    input  logic [AW-1:0]            pipe_wa,
    input  logic [DW-1:0]            pipe_wd,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [AW-1:0]            req_wa,
    input  logic [DW-1:0]            req_wd,
    input  logic [AW-1:0]            chk_a1,
    input  logic [AW-1:0]            chk_a2,
    output logic                     pend1,
    output logic                     pend2,
    output logic                     we3,
    output logic [AW-1:0]            wa3,
    output logic [DW-1:0]            wd3,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    rf_wr_t                      push_data;
    rf_wr_t                      head_data;
    logic                        push;
    logic                        pop;
    logic [CW-1:0]               fifo_count;
    logic [DEPTH-1:0]            ent_valid;
    logic [DEPTH-1:0][RF_AW-1:0] ent_wa;

    // Writes to register 0 still complete the handshake but are silently dropped.
    always_comb begin
        req_ready = !reset && (fifo_count != FULL_CNT);
        push      = req_valid && req_ready && (req_wa != RF_ZERO_ADDR);
        push_data = '{wa: req_wa, wd: req_wd};
        pop       = !reset && !pipe_we && (fifo_count != '0);
    end

    rf_wb_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_data(push_data),
        .pop      (pop),
        .head_data(head_data),
        .count    (fifo_count),
        .ent_valid(ent_valid),
        .ent_wa   (ent_wa)
    );

    // Pipeline writeback always wins the port; the queue only fills idle slots.
    always_comb begin
        we3 = 1'b0;
        wa3 = '0;
        wd3 = '0;
        if (!reset) begin
            if (pipe_we) begin
                we3 = 1'b1;
                wa3 = pipe_wa;
                wd3 = pipe_wd;
            end else if (fifo_count != '0) begin
                we3 = 1'b1;
                wa3 = head_data.wa;
                wd3 = head_data.wd;
            end
        end
    end

    // The entry draining this cycle stays pending until its write has landed.
    always_comb begin
        pend1 = 1'b0;
        pend2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i] && (ent_wa[i] == chk_a1)) pend1 = 1'b1;
            if (ent_valid[i] && (ent_wa[i] == chk_a2)) pend2 = 1'b1;
        end
        if (chk_a1 == RF_ZERO_ADDR) pend1 = 1'b0;
        if (chk_a2 == RF_ZERO_ADDR) pend2 = 1'b0;
    end

    assign count = fifo_count;

endmodule

// File: tb/tb_rf_wb_queue.sv
// Directed bench for rf_wb_queue: expected register-file writes go into a scoreboard
// queue, a negedge monitor pops and compares every we3 pulse.
module tb_rf_wb_queue;

    logic        clk;
    logic        reset;
    logic        pipe_we;
    logic [4:0]  pipe_wa;
    logic [31:0] pipe_wd;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_wa;
    logic [31:0] req_wd;
    logic [4:0]  chk_a1;
    logic [4:0]  chk_a2;
    logic        pend1;
    logic        pend2;
    logic        we3;
    logic [4:0]  wa3;
    logic [31:0] wd3;
    logic [2:0]  count;

    int compared   = 0;
    int mismatched = 0;

    logic [36:0] exp_q [$];
    logic [31:0] rf_model [32];

    rf_wb_queue #(.DEPTH(4), .AW(5), .DW(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .pipe_we  (pipe_we),
        .pipe_wa  (pipe_wa),
        .pipe_wd  (pipe_wd),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_wa   (req_wa),
        .req_wd   (req_wd),
        .chk_a1   (chk_a1),
        .chk_a2   (chk_a2),
        .pend1    (pend1),
        .pend2    (pend2),
        .we3      (we3),
        .wa3      (wa3),
        .wd3      (wd3),
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every register-file write must match the next scoreboard entry.
    always @(negedge clk) begin
        logic [36:0] exp_w;
        if (we3) begin
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("[TB] FAIL unexpected_write: got wa3=%0d wd3=%h, expected no write", wa3, wd3);
            end else begin
                exp_w = exp_q.pop_front();
                if ({wa3, wd3} !== exp_w) begin
                    mismatched++;
                    $display("[TB] FAIL wb_write: got wa3=%0d wd3=%h, expected wa3=%0d wd3=%h",
                             wa3, wd3, exp_w[36:32], exp_w[31:0]);
                end
            end
            rf_model[wa3] = wd3;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expPush(input logic [4:0] wa, input logic [31:0] wd);
        exp_q.push_back({wa, wd});
    endtask

    task automatic applyStimulus(input logic pwe, input logic [4:0] pwa, input logic [31:0] pwd,
                                 input logic rv, input logic [4:0] rwa, input logic [31:0] rwd);
        pipe_we   = pwe;
        pipe_wa   = pwa;
        pipe_wd   = pwd;
        req_valid = rv;
        req_wa    = rwa;
        req_wd    = rwd;
        if (pwe) expPush(pwa, pwd);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf_model[i] = 32'h0;
        chk_a1 = 5'd3;
        chk_a2 = 5'd0;

        // Reset held: pipe_we and a request are both ignored.
        reset = 1'b1;
        pipe_we = 1'b1; pipe_wa = 5'd7; pipe_wd = 32'h55;
        req_valid = 1'b1; req_wa = 5'd3; req_wd = 32'h99;
        @(negedge clk);
        checkOutput("reset_ready", 32'(req_ready), 32'd0);
        checkOutput("reset_we3", 32'(we3), 32'd0);
        checkOutput("reset_count", 32'(count), 32'd0);
        checkOutput("reset_pend1", 32'(pend1), 32'd0);
        step();
        reset = 1'b0;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        checkOutput("post_reset_ready", 32'(req_ready), 32'd1);
        checkOutput("post_reset_count", 32'(count), 32'd0);
        step();

        // Idle drain with no bypass into we3.
        chk_a1 = 5'd5;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'hDEADBEEF);
        expPush(5'd5, 32'hDEADBEEF);
        @(negedge clk);
        checkOutput("drain_no_bypass", 32'(we3), 32'd0);
        checkOutput("drain_pend_before", 32'(pend1), 32'd0);
        step();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        checkOutput("drain_count1", 32'(count), 32'd1);
        checkOutput("drain_pend_during", 32'(pend1), 32'd1);
        step();
        @(negedge clk);
        checkOutput("drain_count0", 32'(count), 32'd0);
        checkOutput("drain_pend_after", 32'(pend1), 32'd0);
        step();

        // Zero address: accepted but dropped.
        chk_a1 = 5'd0;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h1234);
        @(negedge clk);
        checkOutput("zero_ready", 32'(req_ready), 32'd1);
        checkOutput("zero_pend1", 32'(pend1), 32'd0);
        step();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        checkOutput("zero_count", 32'(count), 32'd0);
        checkOutput("zero_we3", 32'(we3), 32'd0);
        step();

        // Reset mid-queue: three writes queued behind pipe traffic are discarded.
        applyStimulus(1'b1, 5'd7, 32'h70, 1'b1, 5'd3, 32'h33);
        step();
        applyStimulus(1'b1, 5'd7, 32'h71, 1'b1, 5'd4, 32'h44);
        step();
        applyStimulus(1'b1, 5'd7, 32'h72, 1'b1, 5'd6, 32'h66);
        step();
        reset = 1'b1;
        pipe_we = 1'b1; pipe_wa = 5'd7; pipe_wd = 32'h73;
        req_valid = 1'b0;
        @(negedge clk);
        checkOutput("midreset_count_before", 32'(count), 32'd3);
        checkOutput("midreset_we3", 32'(we3), 32'd0);
        checkOutput("midreset_ready", 32'(req_ready), 32'd0);
        step();
        reset = 1'b0;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("midreset_idle_count", 32'(count), 32'd0);
            checkOutput("midreset_idle_we3", 32'(we3), 32'd0);
            step();
        end
        checkOutput("midreset_rf3", rf_model[3], 32'h0);
        checkOutput("midreset_rf4", rf_model[4], 32'h0);
        checkOutput("midreset_rf6", rf_model[6], 32'h0);

        // Priority: pipeline holds the port while two entries wait.
        applyStimulus(1'b1, 5'd7, 32'h11, 1'b1, 5'd10, 32'hA0);
        step();
        applyStimulus(1'b1, 5'd7, 32'h11, 1'b1, 5'd11, 32'hB0);
        step();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 5'd7, 32'h11, 1'b0, 5'd0, 32'h0);
            @(negedge clk);
            checkOutput("prio_count_held", 32'(count), 32'd2);
            step();
        end
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        expPush(5'd10, 32'hA0);
        expPush(5'd11, 32'hB0);
        step();
        @(negedge clk);
        checkOutput("prio_count_mid", 32'(count), 32'd1);
        step();
        @(negedge clk);
        checkOutput("prio_count_done", 32'(count), 32'd0);
        step();

        // Full / backpressure with wrap-around of both pointers.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 5'd7, 32'h20 + 32'(i), 1'b1, 5'd12 + 5'(i), 32'hC0 + 32'(i));
            step();
        end
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 5'd7, 32'h30 + 32'(i), 1'b1, 5'd20, 32'hEE);
            @(negedge clk);
            checkOutput("full_ready", 32'(req_ready), 32'd0);
            checkOutput("full_count", 32'(count), 32'd4);
            step();
        end
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd20, 32'hEE);
        expPush(5'd12, 32'hC0);
        @(negedge clk);
        checkOutput("full_ready_on_drain", 32'(req_ready), 32'd0);
        step();
        applyStimulus(1'b1, 5'd7, 32'h40, 1'b1, 5'd20, 32'hEE);
        @(negedge clk);
        checkOutput("unfull_ready", 32'(req_ready), 32'd1);
        checkOutput("unfull_count", 32'(count), 32'd3);
        step();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        expPush(5'd13, 32'hC1);
        expPush(5'd14, 32'hC2);
        expPush(5'd15, 32'hC3);
        expPush(5'd20, 32'hEE);
        @(negedge clk);
        checkOutput("refill_count", 32'(count), 32'd4);
        step();
        for (int i = 0; i < 4; i++) step();
        @(negedge clk);
        checkOutput("full_drained_count", 32'(count), 32'd0);
        step();

        // Hazard and ordering on register 9.
        chk_a1 = 5'd9;
        chk_a2 = 5'd10;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'hA);
        expPush(5'd9, 32'hA);
        @(negedge clk);
        checkOutput("haz_pend1_empty", 32'(pend1), 32'd0);
        step();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'hB);
        expPush(5'd9, 32'hB);
        @(negedge clk);
        checkOutput("haz_pend1_first", 32'(pend1), 32'd1);
        checkOutput("haz_pend2_other", 32'(pend2), 32'd0);
        step();
        chk_a2 = 5'd9;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        checkOutput("haz_pend1_second", 32'(pend1), 32'd1);
        checkOutput("haz_pend2_second", 32'(pend2), 32'd1);
        step();
        @(negedge clk);
        checkOutput("haz_pend1_clear", 32'(pend1), 32'd0);
        checkOutput("haz_pend2_clear", 32'(pend2), 32'd0);
        step();
        checkOutput("haz_rf9_value", rf_model[9], 32'hB);

        // Everything expected must have reached the port within a bounded time.
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
        checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
